// File: rtl/newton_iter_invsqrt_pkg.sv
// Shared types and constants for the Newton-Raphson inverse-square-root refiner.
// Also holds the fixed-point 1.5 - t step used by the SUB state.
package newton_iter_invsqrt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ   = 3'd1,
        MXY  = 3'd2,
        SUB  = 3'd3,
        MUL  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [31:0] FP_THREE_HALVES = 32'h3FC0_0000;
    localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF         = 32'h7F80_0000;

    localparam logic [31:0] Q230_THREE_HALVES = 32'h6000_0000;

    // r = 1.5 - t computed in unsigned Q2.30; t is never negative on a live path, so a negative t just yields +0
    function automatic logic [31:0] three_halves_minus(input logic [31:0] t);
        logic [55:0] wide;
        logic [31:0] t_fix;
        logic [31:0] r_fix;
        logic [4:0]  lead;
        logic [7:0]  sh;
        logic [31:0] res;
        wide = {1'b1, t[22:0], 32'h0000_0000};
        sh   = 8'd152 - t[30:23];
        if (t[30:23] == 8'd0) begin
            t_fix = 32'd0;
        end else begin
            t_fix = 32'(wide >> sh);
        end
        r_fix = 32'd0;
        lead  = 5'd0;
        if (t[31] || (t[30:23] >= 8'd128) || (t_fix >= Q230_THREE_HALVES)) begin
            res = 32'h0000_0000;
        end else begin
            r_fix = Q230_THREE_HALVES - t_fix;
            for (int i = 0; i < 31; i++) begin
                lead = r_fix[i] ? 5'(i) : lead;
            end
            res = {1'b0, 8'(8'd97 + {3'd0, lead}), 23'((r_fix << (5'd31 - lead)) >> 8)};
        end
        return res;
    endfunction

endpackage

// File: rtl/newton_iter_invsqrt_fp32_mul.sv
// Combinational fp32 multiplier: truncated mantissa, denormals flushed to zero,
// exponent overflow saturated to the largest finite magnitude.
module fp32_mul
    import newton_iter_invsqrt_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product
);

    logic              sign_s;
    logic [47:0]       man_a_s;
    logic [47:0]       man_b_s;
    logic [24:0]       prod_hi_s;
    logic signed [9:0] exp_s;

    // Multiply, normalise by at most one place, then classify the exponent
    always_comb begin
        sign_s    = a[31] ^ b[31];
        man_a_s   = {24'd0, 1'b1, a[22:0]};
        man_b_s   = {24'd0, 1'b1, b[22:0]};
        prod_hi_s = 25'((man_a_s * man_b_s) >> 23);
        exp_s     = signed'({2'b00, a[30:23]}) + signed'({2'b00, b[30:23]}) - 10'sd127
                    + (prod_hi_s[24] ? 10'sd1 : 10'sd0);
        if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
            product = {sign_s, 31'd0};
        end else if (exp_s <= 10'sd0) begin
            product = {sign_s, 31'd0};
        end else if (exp_s >= 10'sd255) begin
            product = {sign_s, 8'hFE, 23'h7F_FFFF};
        end else if (prod_hi_s[24]) begin
            product = {sign_s, exp_s[7:0], prod_hi_s[23:1]};
        end else begin
            product = {sign_s, exp_s[7:0], prod_hi_s[22:0]};
        end
    end

endmodule

// File: rtl/newton_iter_invsqrt.sv
// Multi-cycle Newton-Raphson refinement y = y*(1.5 - x2*y*y), ITER passes,
// one shared fp32 multiplier, valid/ready handshakes on both sides.
module newton_iter_invsqrt
    import newton_iter_invsqrt_pkg::*;
#(
    parameter int ITER = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] y0_in,
    input  logic [31:0] x2_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    state_t      state_r, state_nx_s;
    logic [1:0]  iter_r;
    logic [31:0] y_r, x2_r, t_r, r_r;
    logic        nan_r, inf_r;
    logic        in_ready_r, out_valid_r;
    logic [31:0] out_data_r;
    logic [31:0] mul_a_s, mul_b_s, mul_p_s, sub_r_s;
    logic        accept_s, last_iter_s;

    fp32_mul u_mul (
        .a       (mul_a_s),
        .b       (mul_b_s),
        .product (mul_p_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; ce low freezes everything
    always_comb begin
        accept_s    = ce && in_valid && in_ready_r;
        last_iter_s = (iter_r == 2'(ITER - 1));
        state_nx_s  = state_r;
        if (!ce) begin
            state_nx_s = state_r;
        end else begin
            case (state_r)
                IDLE:    state_nx_s = accept_s ? SQ : IDLE;
                SQ:      state_nx_s = MXY;
                MXY:     state_nx_s = SUB;
                SUB:     state_nx_s = MUL;
                MUL:     state_nx_s = last_iter_s ? DONE : SQ;
                DONE:    state_nx_s = out_ready ? IDLE : DONE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Operand steering for the shared multiplier and the SUB step
    always_comb begin
        sub_r_s = three_halves_minus(t_r);
        case (state_r)
            SQ: begin
                mul_a_s = y_r;
                mul_b_s = y_r;
            end
            MXY: begin
                mul_a_s = x2_r;
                mul_b_s = t_r;
            end
            MUL: begin
                mul_a_s = y_r;
                mul_b_s = r_r;
            end
            default: begin
                mul_a_s = 32'd0;
                mul_b_s = 32'd0;
            end
        endcase
    end

    // Datapath registers: operands captured on accept, one operation per state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_r    <= 32'd0;
            x2_r   <= 32'd0;
            t_r    <= 32'd0;
            r_r    <= 32'd0;
            iter_r <= 2'd0;
            nan_r  <= 1'b0;
            inf_r  <= 1'b0;
        end else if (ce) begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        y_r    <= y0_in;
                        x2_r   <= x2_in;
                        iter_r <= 2'd0;
                        nan_r  <= x2_in[31];
                        inf_r  <= (x2_in[30:23] == 8'd0);
                    end
                end
                SQ, MXY: t_r <= mul_p_s;
                SUB:     r_r <= sub_r_s;
                MUL: begin
                    y_r    <= mul_p_s;
                    iter_r <= iter_r + 2'd1;
                end
                default: y_r <= y_r;
            endcase
        end
    end

    // Registered handshake outputs and result; NaN outranks +Inf
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
        end else if (ce) begin
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            if ((state_r == MUL) && (state_nx_s == DONE)) begin
                out_data_r <= nan_r ? FP_QNAN : (inf_r ? FP_PINF : mul_p_s);
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: doc/newton_iter_invsqrt.md
NEWTON_ITER_INVSQRT -- requirements
Module: newton_iter_invsqrt

Interface
REQ-001 The block SHALL have parameter ITER, default 1, meaning the number of Newton-Raphson refinement iterations (legal values 1..3).
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  reset; asynchronous, active-low.
- ce  input  1  clock enable; when low, all state and outputs hold.
- in_valid  input  1  y0/x2 pair is valid.
- in_ready  output  1  block can accept a pair.
- y0_in  input  32  fp32 initial estimate (magic-constant seed).
- x2_in  input  32  fp32 value of half the original operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  fp32 refined 1/sqrt(x).

Function
REQ-003 The block SHALL accept a pair on a rising edge where ce=1, in_valid=1 and in_ready=1; in_ready SHALL be 1 only in IDLE.
REQ-004 The FSM states SHALL be IDLE, SQ, MXY, SUB, MUL and DONE.
REQ-005 FSM transitions SHALL be:
- IDLE->SQ on accept.
- SQ->MXY->SUB->MUL, one state per ce-enabled cycle.
- MUL->SQ while iterations remain, else MUL->DONE.
- DONE->IDLE when out_ready=1.
REQ-006 The datapath SHALL compute one operation per state:
- SQ: t=y*y.
- MXY: t=x2*t.
- SUB: r=1.5-t.
- MUL: y=y*r.
REQ-007 out_valid SHALL rise exactly 4*ITER ce-enabled cycles after the accepting edge, and SHALL be 1 only in DONE.
REQ-008 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 A result SHALL be consumed on an edge where ce=1, out_valid=1 and out_ready=1.
REQ-010 There SHALL be no back-to-back path: a new input is accepted no earlier than the cycle after the consuming edge.
REQ-011 When ce=0, the FSM, the iteration counter, all datapath registers and all outputs SHALL hold; in_valid/out_ready SHALL be ignored.
REQ-012 fp32 multiply SHALL follow these rules:
- Result mantissa is truncated (round toward zero).
- Denormal inputs or results flush to +/-0.
- Exponent overflow saturates to the largest finite value of the correct sign.
REQ-013 SUB SHALL work as follows:
- Convert t to unsigned Q2.30 with truncation.
- r_fixed = 1.5 - t_fixed.
- If r_fixed <= 0 or t >= 2.0, r = +0.
- Otherwise renormalize to fp32 with a truncated mantissa.
REQ-014 If x2_in sign bit is 1, out_data SHALL be 32'h7FC00000, with the same latency.
REQ-015 If x2_in exponent is 0 (zero or denormal), out_data SHALL be 32'h7F800000, with the same latency.
REQ-016 If both REQ-014 and REQ-015 conditions apply, REQ-014 SHALL take priority.
REQ-017 Input operands SHALL be registered on accept; later changes on y0_in/x2_in SHALL not affect an operation in progress.

Reset
REQ-018 While rst=0, the block SHALL immediately force:
- FSM to IDLE, iteration counter to 0 and datapath registers to 0.
- in_ready=0, out_valid=0, out_data=32'h00000000.
REQ-019 On the first enabled edge after rst deasserts, in_ready SHALL be 1.
REQ-020 Reset asserted mid-operation or in DONE SHALL abort the operation, with no partial result output.

Structure
REQ-021 A shared package SHALL hold:
- the FSM state enum;
- fp32 field widths and bias (127);
- the constants FP_THREE_HALVES=32'h3FC00000, FP_QNAN=32'h7FC00000 and FP_PINF=32'h7F800000.
REQ-022 The fp32 multiplier SHALL be a separate combinational sub-module fp32_mul, instantiated once and time-shared across SQ, MXY and MUL.

Verification
REQ-023 The bench SHALL cover these scenarios:
- ITER=1, y0_in=3EF759DF, x2_in=40000000 (x=4.0) -> out_valid 4 cycles after accept; |out_data - 0.5| < 0.002.
- ITER=1, y0_in=3F7759DF, x2_in=3F000000 (x=1.0) -> out_data within 0.002 of 0.99831; ITER=2 -> within 0.0005 of 1.0; latency 8.
- x2_in=BF000000 -> out_data=7FC00000; x2_in=00000000 -> out_data=7F800000; latency unchanged in both cases.
- Result pending with out_ready=0 for 10 cycles -> out_data and out_valid stable; in_ready=0 throughout; consumed on the out_ready edge; IDLE the next cycle.
- ce held low for 5 cycles mid-operation -> latency extended by exactly 5 cycles; result identical to the uninterrupted run.
- rst low in MXY -> out_valid=0 and in_ready=0 immediately; after release, a fresh x=4.0 operation completes correctly.
